uart_tx_fifo_ctrl: RTL

Transmit-side FIFO controller for the UART. It accepts bytes from the CPU MMIO write path into an external 512x8 BRAM used as a circular buffer. It sequences BRAM reads and hands each byte to the `uart_tx` serializer through a start/busy handshake. It owns the read pointer, the write pointer and the occupancy count, and exposes full/empty status to software.

---
 rtl/uart_tx_fifo_ctrl_if.sv | 33 +++
 rtl/uart_tx_fifo_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Signal bundle between the TX FIFO controller and its CPU write port, BRAM and uart_tx.
// The controller connects through the slave modport; the surrounding system uses master.
interface uart_tx_fifo_ctrl_if #(
    parameter int unsigned DEPTH_LOG2 = 9
);
    logic                  wr_valid;
    logic [7:0]            wr_data;
    logic                  wr_ready;
    logic                  flush;
    logic [DEPTH_LOG2-1:0] tx_fifo_wa;
    logic [7:0]            tx_fifo_wd;
    logic                  tx_fifo_wen;
    logic [DEPTH_LOG2-1:0] tx_fifo_ra;
    logic [7:0]            tx_fifo_rd;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  tx_busy;
    logic [DEPTH_LOG2:0]   count;
    logic                  empty;
    logic                  full;

    modport master (
        output wr_valid, wr_data, flush, tx_fifo_rd, tx_busy,
        input  wr_ready, tx_fifo_wa, tx_fifo_wd, tx_fifo_wen, tx_fifo_ra,
        input  tx_data, tx_start, count, empty, full
    );

    modport slave (
        input  wr_valid, wr_data, flush, tx_fifo_rd, tx_busy,
        output wr_ready, tx_fifo_wa, tx_fifo_wd, tx_fifo_wen, tx_fifo_ra,
        output tx_data, tx_start, count, empty, full
    );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit FIFO controller: circular buffer in external 1-cycle-latency BRAM,
// occupancy count as the only full/empty source, start/busy handshake to uart_tx.
module uart_tx_fifo_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_tx_fifo_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  wr_accept;
    logic                  pop;

    assign bus.full       = (count_q == DEPTH);
    assign bus.empty      = (count_q == '0);
    assign bus.wr_ready   = !bus.full && !bus.flush;
    assign bus.count      = count_q;
    assign bus.tx_fifo_ra = rd_ptr;
    assign wr_accept      = bus.wr_valid && bus.wr_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // READ is a dead cycle so a read never overlaps the BRAM commit of the same slot.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (count_q != '0 && !bus.tx_busy) state_nxt = READ;
                READ:      state_nxt = LATCH;
                LATCH:     state_nxt = WAIT_BUSY;
                WAIT_BUSY: if (bus.tx_busy) state_nxt = WAIT_DONE;
                WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pop = 1'b0;
        if (state == LATCH && !bus.flush) pop = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count_q         <= '0;
            bus.tx_fifo_wa  <= '0;
            bus.tx_fifo_wd  <= '0;
            bus.tx_fifo_wen <= 1'b0;
            bus.tx_data     <= '0;
            bus.tx_start    <= 1'b0;
        end else begin
            bus.tx_fifo_wen <= wr_accept;
            bus.tx_start    <= pop;
            if (wr_accept) begin
                bus.tx_fifo_wa <= wr_ptr;
                bus.tx_fifo_wd <= bus.wr_data;
                wr_ptr         <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                bus.tx_data <= bus.tx_fifo_rd;
                rd_ptr      <= rd_ptr + PTR_ONE;
            end
            if (bus.flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                case ({wr_accept, pop})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule
